// File: rtl/cp0_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_defs (package)
// Purpose  : Shared CP0 definitions: register numbers, ExcCodes, exception
//            unit excepttype codes, Status/Cause write masks and the
//            excepttype decoder used by the CP0 register file.
// Revision : 1.0 - initial release
// ============================================================================
package cp0_defs;

  // CP0 register numbers (sel 0)
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // excepttype codes produced by the exception unit
  localparam logic [31:0] EXCEPT_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXCEPT_INT     = 32'h0000_0001;
  localparam logic [31:0] EXCEPT_ADEL    = 32'h0000_0004;
  localparam logic [31:0] EXCEPT_ADES    = 32'h0000_0005;
  localparam logic [31:0] EXCEPT_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXCEPT_BREAK   = 32'h0000_0009;
  localparam logic [31:0] EXCEPT_RI      = 32'h0000_000a;
  localparam logic [31:0] EXCEPT_OV      = 32'h0000_000c;
  localparam logic [31:0] EXCEPT_ERET    = 32'h0000_000e;

  // Writable fields: Status IM[15:8], EXL, IE; Cause IP[9:8]
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  localparam int STATUS_EXL_BIT = 1;
  localparam int CAUSE_BD_BIT   = 31;

  typedef enum logic [1:0] {
    COMMIT_NONE = 2'd0,
    COMMIT_EXC  = 2'd1,
    COMMIT_ERET = 2'd2
  } commit_e;

  typedef struct packed {
    commit_e    kind;
    logic [4:0] exc_code;
    logic       load_bad;
  } except_t;

  // Map an excepttype code onto the commit action; unknown codes do nothing
  function automatic except_t decode_except(input logic [31:0] et);
    except_t r;
    r.kind     = COMMIT_EXC;
    r.exc_code = EXC_INT;
    r.load_bad = 1'b0;
    case (et)
      EXCEPT_INT:     r.exc_code = EXC_INT;
      EXCEPT_ADEL:    begin r.exc_code = EXC_ADEL; r.load_bad = 1'b1; end
      EXCEPT_ADES:    begin r.exc_code = EXC_ADES; r.load_bad = 1'b1; end
      EXCEPT_SYSCALL: r.exc_code = EXC_SYS;
      EXCEPT_BREAK:   r.exc_code = EXC_BP;
      EXCEPT_RI:      r.exc_code = EXC_RI;
      EXCEPT_OV:      r.exc_code = EXC_OV;
      EXCEPT_ERET:    r.kind = COMMIT_ERET;
      default:        r.kind = COMMIT_NONE;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_regfile_timer.sv
`default_nettype none
// ============================================================================
// Module   : cp0_timer
// Purpose  : CP0 Count/Compare timer. Count advances every second clock via
//            a phase toggle; timer_int_o latches on Count==Compare (Compare
//            non-zero) and is cleared by a Compare write.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        phase_q, phase_d;
  logic        timer_q, timer_d;

  // Next-state: a Count write reloads and realigns the phase; a Compare write acknowledges the interrupt
  always_comb begin
    count_d   = count_q;
    phase_d   = ~phase_q;
    compare_d = compare_q;
    timer_d   = timer_q;
    if (count_we_i) begin
      count_d = data_i;
      phase_d = 1'b0;
    end else if (phase_q) begin
      count_d = count_q + 32'd1;
    end
    if (compare_we_i) begin
      compare_d = data_i;
      timer_d   = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_d = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 32'd0;
      phase_q   <= 1'b0;
      compare_q <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      phase_q   <= phase_d;
      compare_q <= compare_d;
      timer_q   <= timer_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_q;

endmodule
`default_nettype wire

// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module   : cp0_regfile
// Purpose  : MIPS32 CP0 register file (Status, Cause, EPC, BadVAddr, Count,
//            Compare, PRId, Config). Serves MTC0/MFC0 and commits the
//            memory-stage exception code in a single cycle.
// Config   : define CP0_TIMER_EN to include the Count/Compare timer;
//            otherwise Count/Compare read 0 and timer_int_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic [31:0] count_w, compare_w, count_byp_w;
  logic        timer_int_w;

  except_t     exc_w;
  logic        commit_w;
  logic        we_status_w, we_cause_w, we_epc_w, we_count_w, we_compare_w;
  logic [31:0] status_wval_w, cause_wval_w;

  assign exc_w        = decode_except(excepttype_i);
  assign commit_w     = (exc_w.kind != COMMIT_NONE);
  assign we_status_w  = we_i && (waddr_i == CP0_REG_STATUS);
  assign we_cause_w   = we_i && (waddr_i == CP0_REG_CAUSE);
  assign we_epc_w     = we_i && (waddr_i == CP0_REG_EPC);
  assign we_count_w   = we_i && (waddr_i == CP0_REG_COUNT);
  assign we_compare_w = we_i && (waddr_i == CP0_REG_COMPARE);

  // Value a masked MTC0 would leave in Status / Cause
  assign status_wval_w = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
  assign cause_wval_w  = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (we_count_w),
    .compare_we_i (we_compare_w),
    .data_i       (data_i),
    .count_o      (count_w),
    .compare_o    (compare_w),
    .timer_int_o  (timer_int_w)
  );
  assign count_byp_w = data_i;
`else
  assign count_w     = 32'd0;
  assign compare_w   = 32'd0;
  assign timer_int_w = 1'b0;
  assign count_byp_w = 32'd0;
`endif

  // Next-state: MTC0 first, then interrupt sampling, then exception/ERET commit which overrides MTC0
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (!commit_w) begin
      if (we_status_w) status_d = status_wval_w;
      if (we_cause_w)  cause_d  = cause_wval_w;
      if (we_epc_w)    epc_d    = data_i;
    end
    cause_d[15:10] = int_i;
    cause_d[15]    = int_i[5] | timer_int_w;
    if (exc_w.kind == COMMIT_EXC) begin
      if (!status_q[STATUS_EXL_BIT]) begin
        epc_d                 = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                  : current_inst_addr_i;
        cause_d[CAUSE_BD_BIT] = is_in_delayslot_i;
      end
      status_d[STATUS_EXL_BIT] = 1'b1;
      cause_d[6:2]             = exc_w.exc_code;
      if (exc_w.load_bad) badvaddr_d = bad_addr_i;
    end else if (exc_w.kind == COMMIT_ERET) begin
      status_d[STATUS_EXL_BIT] = 1'b0;
    end
  end

  // CP0 architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // MFC0 read mux with same-cycle MTC0 bypass (masked the same way the write is)
  always_comb begin
    logic byp;
    byp    = we_i && (waddr_i == raddr_i);
    data_o = 32'd0;
    case (raddr_i)
      CP0_REG_BADVADDR: data_o = badvaddr_q;
      CP0_REG_COUNT:    data_o = byp ? count_byp_w : count_w;
      CP0_REG_COMPARE:  data_o = byp ? count_byp_w : compare_w;
      CP0_REG_STATUS:   data_o = byp ? status_wval_w : status_q;
      CP0_REG_CAUSE:    data_o = byp ? cause_wval_w : cause_q;
      CP0_REG_EPC:      data_o = byp ? data_i : epc_q;
      CP0_REG_PRID:     data_o = PRID_VAL;
      CP0_REG_CONFIG:   data_o = CONFIG_VAL;
      default:          data_o = 32'd0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign count_o     = count_w;
  assign compare_o   = compare_w;
  assign timer_int_o = timer_int_w;

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_regfile
// Purpose  : Self-checking bench for cp0_regfile. Expected values are queued
//            when stimulus is applied and popped when DUT outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_regfile;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] data_o;
  logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_errors = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  cp0_regfile dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .raddr_i             (raddr_i),
    .data_i              (data_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .bad_addr_i          (bad_addr_i),
    .data_o              (data_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .badvaddr_o          (badvaddr_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .timer_int_o         (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_underflow: got %08h expected none", obs);
    end else begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    raddr_i = a;
    sb_push(tag, exp);
    #1;
    sb_pop(data_o);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic raise(input logic [31:0] code, input logic [31:0] pc,
                       input logic ds, input logic [31:0] bad);
    excepttype_i = code; current_inst_addr_i = pc;
    is_in_delayslot_i = ds; bad_addr_i = bad;
    tick();
    excepttype_i = 32'd0; is_in_delayslot_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; raddr_i = 5'd0; data_i = 32'd0;
    int_i = 6'd0; excepttype_i = 32'd0; current_inst_addr_i = 32'd0;
    is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    sb_push("rst_status", 32'h0040_0000); sb_push("rst_cause", 32'd0);
    sb_push("rst_epc", 32'd0); sb_push("rst_badvaddr", 32'd0);
    sb_push("rst_count", 32'd0); sb_push("rst_compare", 32'd0);
    sb_push("rst_timer", 32'd0);
    sb_pop(status_o); sb_pop(cause_o); sb_pop(epc_o); sb_pop(badvaddr_o);
    sb_pop(count_o); sb_pop(compare_o); sb_pop({31'd0, timer_int_o});
    rd(5'd12, 32'h0040_0000, "rd_status_rst");
    rd(5'd13, 32'd0, "rd_cause_rst");
    rd(5'd14, 32'd0, "rd_epc_rst");
    rd(5'd15, 32'h0000_4220, "rd_prid");
    rd(5'd16, 32'h0000_8000, "rd_config");
    rd(5'd3, 32'd0, "rd_unmapped");

    // Status write mask and bypass
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hFFFF_FFFF;
    rd(5'd12, 32'h0040_FF03, "byp_status");
    tick(); we_i = 1'b0;
    sb_push("status_masked", 32'h0040_FF03); sb_pop(status_o);
    mtc0(5'd12, 32'h0000_FF01);
    sb_push("status_exl_clr", 32'h0040_FF01); sb_pop(status_o);

    // Cause write mask, read-only PRId, EPC full write
    we_i = 1'b1; waddr_i = 5'd13; data_i = 32'hFFFF_FFFF;
    rd(5'd13, 32'h0000_0300, "byp_cause");
    tick(); we_i = 1'b0;
    sb_push("cause_masked", 32'h0000_0300); sb_pop(cause_o);
    we_i = 1'b1; waddr_i = 5'd15; data_i = 32'd0;
    rd(5'd15, 32'h0000_4220, "byp_prid_ro");
    tick(); we_i = 1'b0;
    rd(5'd15, 32'h0000_4220, "prid_ro");
    mtc0(5'd8, 32'hAAAA_5555);
    sb_push("badvaddr_ro", 32'd0); sb_pop(badvaddr_o);
    we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hDEAD_BEEF;
    rd(5'd14, 32'hDEAD_BEEF, "byp_epc");
    tick(); we_i = 1'b0;
    sb_push("epc_write", 32'hDEAD_BEEF); sb_pop(epc_o);

    // Syscall in delay slot with EXL=0
    raise(32'h8, 32'hBFC0_0100, 1'b1, 32'd0);
    sb_push("sys_epc", 32'hBFC0_00FC); sb_push("sys_cause", 32'h8000_0320);
    sb_push("sys_status", 32'h0040_FF03);
    sb_pop(epc_o); sb_pop(cause_o); sb_pop(status_o);

    // AdEL with EXL=1: EPC/BD held, BadVAddr loaded
    raise(32'h4, 32'h0040_0000, 1'b0, 32'h0000_0003);
    sb_push("adel_epc", 32'hBFC0_00FC); sb_push("adel_badv", 32'h0000_0003);
    sb_push("adel_cause", 32'h8000_0310);
    sb_pop(epc_o); sb_pop(badvaddr_o); sb_pop(cause_o);

    // Break does not load BadVAddr
    raise(32'h9, 32'h0040_0010, 1'b0, 32'h0000_0055);
    sb_push("bp_badv", 32'h0000_0003); sb_push("bp_cause", 32'h8000_0324);
    sb_pop(badvaddr_o); sb_pop(cause_o);

    // Undefined code is ignored
    raise(32'h2, 32'h0000_1000, 1'b1, 32'h0000_0077);
    sb_push("undef_status", 32'h0040_FF03); sb_push("undef_epc", 32'hBFC0_00FC);
    sb_push("undef_cause", 32'h8000_0324); sb_push("undef_badv", 32'h0000_0003);
    sb_pop(status_o); sb_pop(epc_o); sb_pop(cause_o); sb_pop(badvaddr_o);

    // ERET overrides a simultaneous Status write
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'd0;
    raise(32'he, 32'h0000_2000, 1'b0, 32'd0);
    we_i = 1'b0;
    sb_push("eret_status", 32'h0040_FF01); sb_push("eret_cause", 32'h8000_0324);
    sb_pop(status_o); sb_pop(cause_o);

    // Hardware interrupt lines sampled into Cause[15:10]
    int_i = 6'b100101;
    tick();
    sb_push("int_cause", 32'h8000_9724); sb_pop(cause_o);
    int_i = 6'd0;
    tick();
    sb_push("int_cause_clr", 32'h8000_0324); sb_pop(cause_o);

    // Interrupt commit overrides a same-cycle EPC write
    we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h0000_1234;
    raise(32'h1, 32'h8000_0000, 1'b0, 32'd0);
    we_i = 1'b0;
    sb_push("int_epc", 32'h8000_0000); sb_push("int_exc_cause", 32'h0000_0300);
    sb_push("int_status", 32'h0040_FF03);
    sb_pop(epc_o); sb_pop(cause_o); sb_pop(status_o);
    raise(32'he, 32'h0, 1'b0, 32'd0);
    sb_push("eret2_status", 32'h0040_FF01); sb_pop(status_o);

`ifdef CP0_TIMER_EN
    begin
      int cyc;
      mtc0(5'd11, 32'd10);
      we_i = 1'b1; waddr_i = 5'd9; data_i = 32'd0;
      rd(5'd9, 32'd0, "byp_count");
      tick(); we_i = 1'b0;
      sb_push("cmp_val", 32'd10); sb_pop(compare_o);
      cyc = 0;
      for (int i = 0; i < 60 && count_o != 32'd10; i++) begin
        tick();
        cyc++;
      end
      sb_push("count_to_10_cycles", 32'd20); sb_pop(cyc);
      sb_push("timer_pre", 32'd0); sb_pop({31'd0, timer_int_o});
      tick();
      sb_push("timer_set", 32'd1); sb_pop({31'd0, timer_int_o});
      tick();
      sb_push("cause_ip7", 32'd1); sb_pop({31'd0, cause_o[15]});
      sb_push("timer_hold", 32'd1); sb_pop({31'd0, timer_int_o});
      mtc0(5'd11, 32'd0);
      sb_push("timer_clr", 32'd0); sb_pop({31'd0, timer_int_o});
      mtc0(5'd9, 32'hFFFF_FFFF);
      tick();
      sb_push("count_hold", 32'hFFFF_FFFF); sb_pop(count_o);
      tick();
      sb_push("count_wrap", 32'd0); sb_pop(count_o);
    end
`else
    we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd7;
    rd(5'd11, 32'd0, "byp_compare_off");
    tick(); we_i = 1'b0;
    mtc0(5'd9, 32'd5);
    repeat (3) tick();
    sb_push("count_off", 32'd0); sb_push("compare_off", 32'd0);
    sb_push("timer_off", 32'd0);
    sb_pop(count_o); sb_pop(compare_o); sb_pop({31'd0, timer_int_o});
    rd(5'd9, 32'd0, "rd_count_off");
`endif

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb_push("arst_status", 32'h0040_0000); sb_push("arst_epc", 32'd0);
    sb_push("arst_cause", 32'd0);
    sb_pop(status_o); sb_pop(epc_o); sb_pop(cause_o);
    tick();
    rst = 1'b0;

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
